// File: rtl/tcdm_bank_responder.sv
// Single-bank TCDM responder: round-robin arbitration of N_PORTS masters onto one SRAM array.
// Grant is combinational, response one cycle later; define TCDM_BANK_STALL_EN for LFSR grant stalling.
module tcdm_bank_responder #(
  parameter int unsigned    N_PORTS   = 4,
  parameter int unsigned    DW        = 32,
  parameter int unsigned    AW        = 32,
  parameter int unsigned    MEM_WORDS = 1024,
  parameter logic [AW-1:0]  BASE_ADDR = 32'h1000_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_PORTS-1:0]            tcdm_req,
  input  logic [N_PORTS-1:0][AW-1:0]    tcdm_add,
  input  logic [N_PORTS-1:0]            tcdm_wen,
  input  logic [N_PORTS-1:0][DW/8-1:0]  tcdm_be,
  input  logic [N_PORTS-1:0][DW-1:0]    tcdm_data,
  output logic [N_PORTS-1:0]            tcdm_gnt,
  output logic [N_PORTS-1:0][DW-1:0]    tcdm_r_data,
  output logic [N_PORTS-1:0]            tcdm_r_valid,
  output logic [31:0]                   conflict_cnt_o
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned OB = $clog2(NB);

  logic [DW-1:0]      mem_q [MEM_WORDS];
  logic [PW-1:0]      ptr_q, ptr_d, win;
  logic               found, stall, xfer;
  logic [N_PORTS-1:0] gnt;
  logic [IW-1:0]      idx;
  logic               rsp_vld_q, rsp_rd_q;
  logic [PW-1:0]      rsp_port_q;
  logic [DW-1:0]      rsp_dat_q;
  logic [31:0]        conflict_cnt_q, conflict_cnt_d;

`ifdef TCDM_BANK_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= int'(N_PORTS); i++) begin
      automatic int p = (int'(ptr_q) + i) % int'(N_PORTS);
      if (!found && tcdm_req[p]) begin
        found = 1'b1;
        win   = PW'(p);
      end
    end
  end

  assign xfer = found & ~stall & ~rst_i;

  always_comb begin
    gnt = '0;
    if (xfer) gnt[win] = 1'b1;
  end

  assign tcdm_gnt = gnt;
  assign idx      = IW'((tcdm_add[win] - BASE_ADDR) >> OB);
  assign ptr_d    = xfer ? win : ptr_q;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((|(tcdm_req & ~gnt)) && (conflict_cnt_q != 32'hFFFF_FFFF))
      conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  // Array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (xfer && !tcdm_wen[win]) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (tcdm_be[win][k]) mem_q[idx][8*k +: 8] <= tcdm_data[win][8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q          <= PW'(N_PORTS - 1);
      rsp_vld_q      <= 1'b0;
      rsp_rd_q       <= 1'b0;
      rsp_port_q     <= '0;
      rsp_dat_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      rsp_vld_q      <= xfer;
      rsp_rd_q       <= tcdm_wen[win];
      rsp_port_q     <= win;
      conflict_cnt_q <= conflict_cnt_d;
      if (xfer && tcdm_wen[win]) rsp_dat_q <= mem_q[idx];
    end
  end

  // Masking with rst_i drops a response whose grant preceded reset.
  always_comb begin
    tcdm_r_valid = '0;
    tcdm_r_data  = '0;
    if (rsp_vld_q && !rst_i) begin
      tcdm_r_valid[rsp_port_q] = 1'b1;
      if (rsp_rd_q) tcdm_r_data[rsp_port_q] = rsp_dat_q;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed self-checking bench for tcdm_bank_responder (4 ports, 32-bit, 1024 words).
module tb_tcdm_bank_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req, wen, gnt, rv;
  logic [3:0][31:0] add, wdat, rdat;
  logic [3:0][3:0]  be;
  logic [31:0]      cc;
  int               chk = 0;
  int               pass = 0;

  always #5 clk = ~clk;

  tcdm_bank_responder dut (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req(req), .tcdm_add(add), .tcdm_wen(wen), .tcdm_be(be), .tcdm_data(wdat),
    .tcdm_gnt(gnt), .tcdm_r_data(rdat), .tcdm_r_valid(rv), .conflict_cnt_o(cc)
  );

`ifdef TCDM_BANK_STALL_EN
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end
`endif

  // One transaction on port p; waits (bounded) for the grant, returns what was seen.
  task automatic access(input int p, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int waits, output logic [3:0] g,
                        output logic [3:0] v, output logic [31:0] rd);
    @(posedge clk); #1;
    req[p] = 1'b1; add[p] = a; wen[p] = w; be[p] = b; wdat[p] = d;
    #1;
    waits = 0;
    while (gnt[p] !== 1'b1 && waits < 64) begin
      @(posedge clk); #2;
      waits++;
    end
    g = gnt;
    @(posedge clk); #1;
    req[p] = 1'b0;
    v  = rv;
    rd = rdat[p];
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; wen = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else pass++;
    chk++; if (rv !== 4'b0000) $display("FAIL reset_rvalid got %b exp 0000", rv); else pass++;
    chk++; if (rdat !== '0) $display("FAIL reset_rdata got %h exp 0", rdat); else pass++;
    chk++; if (cc !== 32'd0) $display("FAIL reset_conflict got %0d exp 0", cc); else pass++;
    rst = 1'b0; req = 4'b0000;
  endtask

  task automatic test_write_read();
    int w; logic [3:0] g, v; logic [31:0] rd;
    access(0, BASE + 32'd8, 1'b0, 4'hF, 32'hDEADBEEF, w, g, v, rd);
    chk++; if (g !== 4'b0001) $display("FAIL wr_gnt got %b exp 0001", g); else pass++;
`ifndef TCDM_BANK_STALL_EN
    chk++; if (w !== 0) $display("FAIL wr_gnt_latency got %0d exp 0", w); else pass++;
`endif
    chk++; if (v !== 4'b0001 || rd !== 32'd0) $display("FAIL wr_resp got v=%b d=%h exp v=0001 d=0", v, rd); else pass++;
    access(0, BASE + 32'd8, 1'b1, 4'h0, 32'd0, w, g, v, rd);
    chk++; if (g !== 4'b0001) $display("FAIL rd_gnt got %b exp 0001", g); else pass++;
    chk++; if (v !== 4'b0001 || rd !== 32'hDEADBEEF) $display("FAIL rd_resp got v=%b d=%h exp v=0001 d=deadbeef", v, rd); else pass++;
  endtask

  task automatic test_byte_enable();
    int w; logic [3:0] g, v; logic [31:0] rd;
    access(1, BASE + 32'd12, 1'b0, 4'hF, 32'h11223344, w, g, v, rd);
    access(1, BASE + 32'd12, 1'b0, 4'b0101, 32'hAABBCCDD, w, g, v, rd);
    access(1, BASE + 32'd12, 1'b1, 4'h0, 32'd0, w, g, v, rd);
    chk++; if (v !== 4'b0010 || rd !== 32'h11BB33DD) $display("FAIL byte_en got v=%b d=%h exp v=0010 d=11bb33dd", v, rd); else pass++;
  endtask

  task automatic test_alias();
    int w; logic [3:0] g, v; logic [31:0] rd;
    access(3, BASE + 32'd4, 1'b0, 4'hF, 32'h5A5A0001, w, g, v, rd);
    access(2, BASE + 32'd4096 + 32'd4, 1'b1, 4'h0, 32'd0, w, g, v, rd);
    chk++; if (v !== 4'b0100 || rd !== 32'h5A5A0001) $display("FAIL alias got v=%b d=%h exp v=0100 d=5a5a0001", v, rd); else pass++;
    chk++; if (rdat[0] !== 32'd0 || rdat[1] !== 32'd0 || rdat[3] !== 32'd0)
      $display("FAIL alias_others got %h exp 0 on ports 0,1,3", rdat); else pass++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    req[0] = 1'b1; wen[0] = 1'b0; be[0] = 4'hF; add[0] = BASE + 32'd20; wdat[0] = 32'h0BADF00D;
    #1;
    chk++; if (gnt !== 4'b0001) $display("FAIL b2b_wr_gnt got %b exp 0001", gnt); else pass++;
    @(posedge clk); #1;
    wen[0] = 1'b1;
    chk++; if (rv !== 4'b0001 || rdat[0] !== 32'd0) $display("FAIL b2b_wr_resp got v=%b d=%h exp v=0001 d=0", rv, rdat[0]); else pass++;
    #1;
    chk++; if (gnt !== 4'b0001) $display("FAIL b2b_rd_gnt got %b exp 0001", gnt); else pass++;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk++; if (rv !== 4'b0001 || rdat[0] !== 32'h0BADF00D) $display("FAIL b2b_rd_resp got v=%b d=%h exp v=0001 d=0badf00d", rv, rdat[0]); else pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, prev_g;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int p = 0; p < 4; p++) add[p] = BASE + 32'(16 * p);
    wen = 4'b1111; req = 4'b1111; prev_g = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      chk++; if (gnt !== exp_g) $display("FAIL rr_gnt[%0d] got %b exp %b", i, gnt, exp_g); else pass++;
      chk++; if (rv !== prev_g) $display("FAIL rr_rvalid[%0d] got %b exp %b", i, rv, prev_g); else pass++;
      prev_g = exp_g;
      @(posedge clk); #1;
    end
    req = 4'b0000;
    chk++; if (cc !== 32'd8) $display("FAIL rr_conflict got %0d exp 8", cc); else pass++;
    chk++; if (rv !== 4'b1000) $display("FAIL rr_last_rvalid got %b exp 1000", rv); else pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req[1] = 1'b1; wen[1] = 1'b1; add[1] = BASE;
    #1;
    chk++; if (gnt !== 4'b0010) $display("FAIL rstmid_gnt got %b exp 0010", gnt); else pass++;
    @(posedge clk); #1;
    req[1] = 1'b0; rst = 1'b1;
    #1;
    chk++; if (rv !== 4'b0000) $display("FAIL rstmid_rvalid got %b exp 0000", rv); else pass++;
    @(posedge clk); #1;
    chk++; if (rv !== 4'b0000) $display("FAIL rstmid_rvalid2 got %b exp 0000", rv); else pass++;
    chk++; if (cc !== 32'd0) $display("FAIL rstmid_conflict got %0d exp 0", cc); else pass++;
    rst = 1'b0; req = 4'b0110; wen = 4'b1111;
    #1;
    chk++; if (gnt !== 4'b0010) $display("FAIL rstmid_ptr got %b exp 0010", gnt); else pass++;
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

`ifdef TCDM_BANK_STALL_EN
  task automatic test_stall();
    int w, nrd, nrv, cyc; logic [3:0] g, v; logic [31:0] rd, exp_d; logic pend, granted;
    for (int i = 0; i < 10; i++)
      access(0, BASE + 32'(4 * (200 + i)), 1'b0, 4'hF, 32'hC0DE0000 + 32'(i), w, g, v, rd);
    nrd = 0; nrv = 0; cyc = 0; pend = 1'b0; exp_d = '0;
    @(posedge clk); #1;
    req[0] = 1'b1; wen[0] = 1'b1; add[0] = BASE + 32'd800;
    while (nrd < 100 && cyc < 2000) begin
      #1;
      granted = gnt[0];
      chk++; if (gnt !== {3'b000, m_lfsr[1:0] != 2'b00})
        $display("FAIL stall_gnt[%0d] got %b lfsr=%h", cyc, gnt, m_lfsr); else pass++;
      @(posedge clk); #1;
      chk++; if (rv !== {3'b000, pend} || (pend && rdat[0] !== exp_d))
        $display("FAIL stall_resp[%0d] got v=%b d=%h exp v=%b d=%h", cyc, rv, rdat[0], pend, exp_d); else pass++;
      if (rv[0]) nrv++;
      pend = granted;
      if (granted) begin
        exp_d = 32'hC0DE0000 + 32'(nrd % 10);
        nrd++;
        add[0] = BASE + 32'(4 * (200 + nrd % 10));
      end
      cyc++;
    end
    req = 4'b0000;
    @(posedge clk); #1;
    chk++; if (rv !== {3'b000, pend} || (pend && rdat[0] !== exp_d))
      $display("FAIL stall_last got v=%b d=%h exp v=%b d=%h", rv, rdat[0], pend, exp_d); else pass++;
    if (rv[0]) nrv++;
    chk++; if (nrd !== 100 || nrv !== 100) $display("FAIL stall_count got grants=%0d rvalid=%0d exp 100/100", nrd, nrv); else pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; wen = '1; be = '0; add = '0; wdat = '0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_alias();
`ifndef TCDM_BANK_STALL_EN
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
`else
    test_stall();
`endif
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
